prm_edge_scan_ctrl: RTL and testbench

//  Sequences obstacle-voxel codes through a bank of N_EDGE parallel PRM edge

---
 rtl/prm_edge_scan_ctrl.sv | 100 ++++++++++
 tb/tb_prm_edge_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_scan_ctrl.sv
// Streams voxel codes into a bank of PRM edge checkers and accumulates a sticky blocked-edge vector.
// Optional PRM_EARLY_EXIT_EN: stop issuing codes once every edge is blocked.
module prm_edge_scan_ctrl #(
   parameter int unsigned N_EDGE  = 8,
   parameter int unsigned CHK_LAT = 1,
   parameter int unsigned CNT_W   = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              vox_valid,
   output logic              vox_ready,
   input  logic [14:0]       vox_code,
   input  logic              vox_last,
   output logic [14:0]       chk_code,
   input  logic [N_EDGE-1:0] chk_mask,
   output logic [N_EDGE-1:0] blocked,
   output logic [CNT_W-1:0]  blocked_cnt,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

   state_t               state;
   logic [CHK_LAT-1:0]   tag_sr;
   logic [CHK_LAT-1:0]   tag_shift;
   logic [N_EDGE-1:0]    blk_nxt;
   logic                 accept;
   logic                 issue;

   function automatic logic [CNT_W-1:0] popcnt(input logic [N_EDGE-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < N_EDGE; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   always_comb begin
      accept  = vox_valid & vox_ready & (state == SCAN);
      blk_nxt = tag_sr[CHK_LAT-1] ? (blocked | chk_mask) : blocked;
`ifdef PRM_EARLY_EXIT_EN
      // Freeze decision uses the mask landing this edge so a fully blocked bank stops at once.
      issue   = accept & ~(&blk_nxt);
`else
      issue   = accept;
`endif
      tag_shift = (tag_sr << 1) | CHK_LAT'(issue);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         tag_sr      <= '0;
         vox_ready   <= 1'b0;
         chk_code    <= '0;
         blocked     <= '0;
         blocked_cnt <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (frame_start) begin
            // Abort or restart: in-flight tags are dropped, and a colliding FIN loses its done pulse.
            state       <= SCAN;
            tag_sr      <= '0;
            blocked     <= '0;
            blocked_cnt <= '0;
            vox_ready   <= 1'b1;
            busy        <= 1'b1;
         end else begin
            blocked <= blk_nxt;
            tag_sr  <= tag_shift;
            if (issue) chk_code <= vox_code;
            case (state)
               IDLE: ;
               SCAN: begin
                  if (accept && vox_last) begin
                     state     <= DRAIN;
                     vox_ready <= 1'b0;
                  end
               end
               DRAIN: begin
                  if (tag_shift == '0) begin
                     state <= FIN;
                     busy  <= 1'b0;
                  end
               end
               FIN: begin
                  blocked_cnt <= popcnt(blocked);
                  done        <= 1'b1;
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Randomized and directed bench for prm_edge_scan_ctrl; the checker bank is modelled as mask = code[3:0].
module tb_prm_edge_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic        vox_valid;
   logic        vox_ready;
   logic [14:0] vox_code;
   logic        vox_last;
   logic [14:0] chk_code;
   logic [3:0]  chk_mask;
   logic [3:0]  blocked;
   logic [2:0]  blocked_cnt;
   logic        busy;
   logic        done;

   int n_chk  = 0;
   int n_pass = 0;

   logic [3:0]  exp_blk;
   logic [14:0] exp_code;

   always #5 clk = ~clk;

   assign chk_mask = chk_code[3:0];

   prm_edge_scan_ctrl #(.N_EDGE(4), .CHK_LAT(1), .CNT_W(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .vox_valid   (vox_valid),
      .vox_ready   (vox_ready),
      .vox_code    (vox_code),
      .vox_last    (vox_last),
      .chk_code    (chk_code),
      .chk_mask    (chk_mask),
      .blocked     (blocked),
      .blocked_cnt (blocked_cnt),
      .busy        (busy),
      .done        (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      vox_valid   = 1'b0;
      vox_last    = 1'b0;
      step();
      frame_start = 1'b0;
      exp_blk     = '0;
      check_eq("start_ready",   32'(vox_ready),   32'd1);
      check_eq("start_busy",    32'(busy),        32'd1);
      check_eq("start_blocked", 32'(blocked),     32'd0);
      check_eq("start_cnt",     32'(blocked_cnt), 32'd0);
      check_eq("start_done",    32'(done),        32'd0);
   endtask

   task automatic send(input logic [14:0] code, input logic v, input logic last);
      logic [3:0] prev_blk;
      check_eq("ready_scan", 32'(vox_ready), 32'd1);
      prev_blk  = exp_blk;
      vox_valid = v;
      vox_code  = code;
      vox_last  = last;
      step();
      if (v) begin
`ifdef PRM_EARLY_EXIT_EN
         if (exp_blk != 4'hF) exp_code = code;
`else
         exp_code = code;
`endif
         exp_blk = exp_blk | code[3:0];
      end
      vox_valid = 1'b0;
      vox_last  = 1'b0;
      check_eq("chk_code", 32'(chk_code), 32'(exp_code));
      check_eq("blocked_lag", 32'(blocked), 32'(prev_blk));
   endtask

   task automatic finish_frame();
      check_eq("drain_ready", 32'(vox_ready), 32'd0);
      check_eq("drain_busy",  32'(busy),      32'd1);
      check_eq("drain_done",  32'(done),      32'd0);
      step();
      check_eq("fin_done",    32'(done),      32'd0);
      check_eq("fin_busy",    32'(busy),      32'd0);
      check_eq("fin_blocked", 32'(blocked),   32'(exp_blk));
      step();
      check_eq("done_pulse",  32'(done),        32'd1);
      check_eq("done_blk",    32'(blocked),     32'(exp_blk));
      check_eq("done_cnt",    32'(blocked_cnt), 32'($countones(exp_blk)));
      check_eq("done_busy",   32'(busy),        32'd0);
      step();
      check_eq("done_low",    32'(done),        32'd0);
      check_eq("hold_blk",    32'(blocked),     32'(exp_blk));
      check_eq("hold_cnt",    32'(blocked_cnt), 32'($countones(exp_blk)));
   endtask

   task automatic finish_collide();
      check_eq("col_ready", 32'(vox_ready), 32'd0);
      step();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      exp_blk     = '0;
      check_eq("col_done",  32'(done),        32'd0);
      check_eq("col_blk",   32'(blocked),     32'd0);
      check_eq("col_cnt",   32'(blocked_cnt), 32'd0);
      check_eq("col_ready", 32'(vox_ready),   32'd1);
      check_eq("col_busy",  32'(busy),        32'd1);
      step();
      check_eq("col_nodone", 32'(done), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      frame_start = 1'b0;
      vox_valid   = 1'b0;
      vox_code    = '0;
      vox_last    = 1'b0;
      exp_blk     = '0;
      exp_code    = '0;
      step();
      step();
      check_eq("rst_ready", 32'(vox_ready),   32'd0);
      check_eq("rst_code",  32'(chk_code),    32'd0);
      check_eq("rst_blk",   32'(blocked),     32'd0);
      check_eq("rst_cnt",   32'(blocked_cnt), 32'd0);
      check_eq("rst_busy",  32'(busy),        32'd0);
      check_eq("rst_done",  32'(done),        32'd0);
      rst_n = 1'b1;

      // Voxels offered while idle must be ignored.
      vox_valid = 1'b1;
      vox_code  = 15'h000F;
      step();
      step();
      vox_valid = 1'b0;
      check_eq("idle_code", 32'(chk_code), 32'd0);
      check_eq("idle_blk",  32'(blocked),  32'd0);

      // Three-voxel frame.
      start_frame();
      send(15'h0001, 1'b1, 1'b0);
      send(15'h0004, 1'b1, 1'b0);
      send(15'h0000, 1'b1, 1'b1);
      finish_frame();

      // Single voxel frame.
      start_frame();
      send(15'h000F, 1'b1, 1'b1);
      finish_frame();

      // Abort after one voxel.
      start_frame();
      send(15'h0008, 1'b1, 1'b0);
      start_frame();
      send(15'h0001, 1'b1, 1'b0);
      send(15'h0002, 1'b1, 1'b1);
      finish_frame();

      // Valid toggling.
      start_frame();
      send(15'h0002, 1'b1, 1'b0);
      send(15'h0004, 1'b0, 1'b0);
      send(15'h0001, 1'b1, 1'b0);
      send(15'h0008, 1'b0, 1'b0);
      send(15'h0000, 1'b1, 1'b1);
      finish_frame();

      // Reset in DRAIN.
      start_frame();
      send(15'h0003, 1'b1, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n    = 1'b1;
      exp_code = '0;
      exp_blk  = '0;
      check_eq("mid_rst_ready", 32'(vox_ready),   32'd0);
      check_eq("mid_rst_code",  32'(chk_code),    32'd0);
      check_eq("mid_rst_blk",   32'(blocked),     32'd0);
      check_eq("mid_rst_cnt",   32'(blocked_cnt), 32'd0);
      check_eq("mid_rst_busy",  32'(busy),        32'd0);
      for (int i = 0; i < 3; i++) begin
         check_eq("mid_rst_done", 32'(done), 32'd0);
         step();
      end

      // FIN collision with frame_start, then a normal completion.
      start_frame();
      send(15'h0005, 1'b1, 1'b1);
      finish_collide();
      send(15'h0002, 1'b1, 1'b1);
      finish_frame();

`ifdef PRM_EARLY_EXIT_EN
      start_frame();
      send(15'h000F, 1'b1, 1'b0);
      send(15'h0001, 1'b1, 1'b0);
      send(15'h0000, 1'b1, 1'b1);
      check_eq("ee_code", 32'(chk_code), 32'h000F);
      finish_frame();
`endif

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         int unsigned n;
         start_frame();
         n = $urandom_range(1, 8);
         for (int unsigned i = 0; i < n; i++) begin
            logic        last;
            logic        v;
            logic [14:0] code;
            last = (i == n - 1);
            v    = last ? 1'b1 : (($urandom % 3) != 0);
            code = 15'($urandom);
            if (!last && ($urandom % 12) == 0) start_frame();
            send(code, v, last);
         end
         if (($urandom % 5) == 0) begin
            finish_collide();
            send(15'($urandom), 1'b1, 1'b1);
         end
         finish_frame();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
